// File: rtl/alu_muldiv.sv
// alu_muldiv: registered ALU for the MIPS EX stage, with an iterative unsigned
// multiply/divide unit that owns the HI/LO registers.
//
// Single-cycle ops write c/zero and pulse done on the edge after start is
// sampled. MULTU and DIVU iterate one bit per cycle and take WIDTH+1 cycles
// in total. During that time busy is high and start is ignored.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op, a, b   request, 4-bit op code, operands (sampled when accepted)
//   c, zero           registered result and its zero flag
//   busy              multi-cycle operation in progress
//   done              one-cycle pulse when c/zero (and hi/lo) are fresh
//   hi, lo            HI/LO registers (MULTU product halves, DIVU rem/quot)
//
// state | meaning
// IDLE  | waiting for start
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one dividend bit per cycle
// FIN   | result-valid cycle (done high); accepts a new start like IDLE
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_PASSA = 4'd0;
  localparam logic [3:0] OP_PASSB = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_MULTU = 4'd8;
  localparam logic [3:0] OP_DIVU  = 4'd9;
  localparam logic [3:0] OP_MFHI  = 4'd10;
  localparam logic [3:0] OP_MFLO  = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  // acc: product high half / partial remainder
  // quo: multiplier shifting out, product low half / quotient shifting in
  // opd: multiplicand / divisor
  logic [WIDTH-1:0] acc, quo, opd;

  logic             last;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_nxt, mul_quo_nxt;
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_acc_nxt, div_quo_nxt;
  logic [WIDTH-1:0] alu_res;

  assign last = (cnt == CW'(1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_FIN: begin
        state_nxt = S_IDLE;
        if (start && op == OP_MULTU)     state_nxt = S_MUL;
        else if (start && op == OP_DIVU) state_nxt = S_DIV;
      end
      S_MUL:   if (last) state_nxt = S_FIN;
      S_DIV:   if (last) state_nxt = S_FIN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = 1'b0;
    if (state == S_MUL || state == S_DIV) busy = 1'b1;
  end

  // ---------------- iteration datapath ----------------
  always_comb begin
    // Shift-add: add multiplicand when the multiplier LSB is set, then shift
    // the whole {acc, quo} pair right, catching the carry in the top bit.
    mul_sum     = {1'b0, acc} + (quo[0] ? {1'b0, opd} : '0);
    mul_acc_nxt = mul_sum[WIDTH:1];
    mul_quo_nxt = {mul_sum[0], quo[WIDTH-1:1]};

    // Restoring divide. The shifted remainder needs WIDTH+1 bits. A zero
    // divisor always "fits", which yields quotient all-ones and remainder = a.
    div_shift   = {acc, quo[WIDTH-1]};
    div_ok      = (div_shift >= {1'b0, opd});
    div_acc_nxt = div_ok ? (div_shift[WIDTH-1:0] - opd) : div_shift[WIDTH-1:0];
    div_quo_nxt = {quo[WIDTH-2:0], div_ok};
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_PASSA: alu_res = a;
      OP_PASSB: alu_res = b;
      OP_ADD:   alu_res = a + b;
      OP_SUB:   alu_res = a - b;
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFHI:  alu_res = hi;
      OP_MFLO:  alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      quo  <= '0;
      opd  <= '0;
      c    <= '0;
      zero <= 1'b1;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_FIN: begin
          if (start) begin
            if (op == OP_MULTU) begin
              acc <= '0;
              quo <= b;
              opd <= a;
              cnt <= CW'(WIDTH);
            end else if (op == OP_DIVU) begin
              acc <= '0;
              quo <= a;
              opd <= b;
              cnt <= CW'(WIDTH);
            end else begin
              done <= 1'b1;
              // reserved codes only pulse done
              if (op <= OP_MFLO) begin
                c    <= alu_res;
                zero <= (alu_res == '0);
              end
            end
          end
        end
        S_MUL: begin
          acc <= mul_acc_nxt;
          quo <= mul_quo_nxt;
          cnt <= cnt - CW'(1);
          if (last) begin
            hi   <= mul_acc_nxt;
            lo   <= mul_quo_nxt;
            c    <= mul_quo_nxt;
            zero <= (mul_quo_nxt == '0);
            done <= 1'b1;
          end
        end
        S_DIV: begin
          acc <= div_acc_nxt;
          quo <= div_quo_nxt;
          cnt <= cnt - CW'(1);
          if (last) begin
            hi   <= div_acc_nxt;
            lo   <= div_quo_nxt;
            c    <= div_quo_nxt;
            zero <= (div_quo_nxt == '0);
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] c, hi, lo;
  logic         zero, busy, done;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [W-1:0] m_c, m_hi, m_lo;
  logic         m_zero;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .c(c), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  function automatic void model_reset();
    m_c = '0; m_zero = 1'b1; m_hi = '0; m_lo = '0;
  endfunction

  function automatic void model_apply(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    logic [W-1:0]   r;
    bit             wr;
    wr = 1;
    r  = '0;
    case (o)
      4'd0:  r = x;
      4'd1:  r = y;
      4'd2:  r = x + y;
      4'd3:  r = x - y;
      4'd4:  r = x & y;
      4'd5:  r = x | y;
      4'd6:  r = x ^ y;
      4'd7:  r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd8:  begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; m_hi = p[2*W-1:W]; m_lo = p[W-1:0]; r = m_lo; end
      4'd9:  begin
               if (y == 0) begin m_lo = '1; m_hi = x; end
               else begin m_lo = x / y; m_hi = x % y; end
               r = m_lo;
             end
      4'd10: r = m_hi;
      4'd11: r = m_lo;
      default: wr = 0;
    endcase
    if (wr) begin m_c = r; m_zero = (r == 0); end
  endfunction

  // drive one request at the current negedge, release it at the next one
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
  endtask

  // drive a multi-cycle request and wait (bounded) for done
  task automatic run_long(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int busy_cnt);
    start = 1'b1; op = o; a = x; b = y;
    lat = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom; end
      if (busy) busy_cnt++;
    end while (!done && lat < 100);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({c, zero, busy, done, hi, lo} !== {m_c, m_zero, 1'b0, 1'b0, m_hi, m_lo}) begin
      errors++;
      $display("FAIL reset_values got c=%h z=%b busy=%b done=%b hi=%h lo=%h", c, zero, busy, done, hi, lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_directed();
    logic [3:0]   ops[5] = '{4'd2, 4'd3, 4'd7, 4'd7, 4'd6};
    logic [W-1:0] as[5]  = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd1, 32'h1234};
    logic [W-1:0] bs[5]  = '{32'd1, 32'd7, 32'd1, 32'hFFFF_FFFF, 32'h1234};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i]);
      model_apply(ops[i], as[i], bs[i]);
      checks++;
      if ({c, zero, done, busy} !== {m_c, m_zero, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL alu_directed[%0d] got c=%h z=%b done=%b busy=%b want c=%h z=%b done=1 busy=0",
                 i, c, zero, done, busy, m_c, m_zero);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL alu_done_pulse[%0d] got done=%b want 0", i, done);
      end
    end
  endtask

  task automatic test_muldiv();
    int lat, bc;
    logic [3:0]   ops[4] = '{4'd8, 4'd9, 4'd9, 4'd8};
    logic [W-1:0] as[4]  = '{32'hFFFF_FFFF, 32'd100, 32'd5, 32'd0};
    logic [W-1:0] bs[4]  = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [3:0]   o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 14; i++) begin
      if (i < 4) begin o = ops[i]; x = as[i]; y = bs[i]; end
      else begin
        o = ($urandom_range(0, 1) == 0) ? 4'd8 : 4'd9;
        x = $urandom;
        y = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      end
      run_long(o, x, y, lat, bc);
      model_apply(o, x, y);
      checks++;
      if (lat != W + 1 || bc != W) begin
        errors++;
        $display("FAIL muldiv_latency[%0d] got lat=%0d busy_cycles=%0d want lat=%0d busy_cycles=%0d", i, lat, bc, W + 1, W);
      end
      checks++;
      if ({c, zero, hi, lo, done, busy} !== {m_c, m_zero, m_hi, m_lo, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL muldiv_result[%0d] op=%0d a=%h b=%h got c=%h z=%b hi=%h lo=%h done=%b want c=%h z=%b hi=%h lo=%h",
                 i, o, x, y, c, zero, hi, lo, done, m_c, m_zero, m_hi, m_lo);
      end
      @(negedge clk);
      if (i == 0) begin
        issue(4'd10, $urandom, $urandom);
        model_apply(4'd10, '0, '0);
        checks++;
        if (c !== 32'd1 || m_c !== 32'd1) begin
          errors++; $display("FAIL mfhi got c=%h want 00000001", c);
        end
        issue(4'd11, $urandom, $urandom);
        model_apply(4'd11, '0, '0);
        checks++;
        if (c !== 32'hFFFF_FFFE || m_c !== 32'hFFFF_FFFE) begin
          errors++; $display("FAIL mflo got c=%h want fffffffe", c);
        end
        // reserved op: only done pulses
        issue(4'd13, $urandom, $urandom);
        checks++;
        if ({c, zero, hi, lo, done} !== {m_c, m_zero, m_hi, m_lo, 1'b1}) begin
          errors++; $display("FAIL reserved_op got c=%h hi=%h lo=%h done=%b want c=%h hi=%h lo=%h done=1", c, hi, lo, done, m_c, m_hi, m_lo);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat, dones, done_lat;
    logic [W-1:0] x, y;
    start = 1'b1; op = 4'd8; a = 32'd3; b = 32'd4;
    lat = 0; dones = 0; done_lat = 0;
    while (lat < W + 8) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin start = 1'b0; a = $urandom; b = $urandom; end
      if (lat == 5) begin start = 1'b1; op = 4'd2; a = $urandom; b = $urandom; end
      if (lat == 6) start = 1'b0;
      if (done) begin dones++; done_lat = lat; end
    end
    model_apply(4'd8, 32'd3, 32'd4);
    checks++;
    if (dones != 1 || done_lat != W + 1) begin
      errors++; $display("FAIL busy_ignore_done got dones=%0d at %0d want 1 at %0d", dones, done_lat, W + 1);
    end
    checks++;
    if ({c, hi, lo} !== {m_c, m_hi, m_lo} || lo !== 32'd12 || hi !== 32'd0) begin
      errors++; $display("FAIL busy_ignore_result got c=%h hi=%h lo=%h want c=%h hi=%h lo=%h", c, hi, lo, m_c, m_hi, m_lo);
    end

    // ADD issued during the FIN cycle
    x = $urandom; y = $urandom;
    run_long(4'd8, x, y, lat, done_lat);
    model_apply(4'd8, x, y);
    x = $urandom; y = $urandom;
    checks++;
    if ({done, lo, hi} !== {1'b1, m_lo, m_hi}) begin
      errors++; $display("FAIL fin_mul got done=%b hi=%h lo=%h want done=1 hi=%h lo=%h", done, hi, lo, m_hi, m_lo);
    end
    issue(4'd2, x, y);
    model_apply(4'd2, x, y);
    checks++;
    if ({c, zero, done, hi, lo} !== {m_c, m_zero, 1'b1, m_hi, m_lo}) begin
      errors++; $display("FAIL fin_add got c=%h z=%b done=%b want c=%h z=%b done=1", c, zero, done, m_c, m_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dones;
    start = 1'b1; op = 4'd8; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({c, zero, busy, done, hi, lo} !== {m_c, m_zero, 1'b0, 1'b0, m_hi, m_lo}) begin
      errors++;
      $display("FAIL reset_mid got c=%h z=%b busy=%b done=%b hi=%h lo=%h", c, zero, busy, done, hi, lo);
    end
    dones = 0;
    repeat (3) begin @(negedge clk); if (done || busy) dones++; end
    rst_n = 1'b1;
    repeat (W + 2) begin @(negedge clk); if (done || busy) dones++; end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL reset_mid_no_done got %0d cycles with done/busy want 0", dones);
    end
    issue(4'd2, 32'd2, 32'd3);
    model_apply(4'd2, 32'd2, 32'd3);
    checks++;
    if ({c, done} !== {32'd5, 1'b1} || m_c !== 32'd5) begin
      errors++; $display("FAIL reset_then_add got c=%h done=%b want c=00000005 done=1", c, done);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0]   o;
    logic [W-1:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 13));
      if (o >= 4'd8) o = o + 4'd2;
      x = $urandom; y = $urandom;
      if (i % 5 == 0) y = x;
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      model_apply(o, x, y);
      checks++;
      if ({c, zero, done, busy, hi, lo} !== {m_c, m_zero, 1'b1, 1'b0, m_hi, m_lo}) begin
        errors++;
        $display("FAIL back_to_back[%0d] op=%0d a=%h b=%h got c=%h z=%b done=%b busy=%b want c=%h z=%b",
                 i, o, x, y, c, zero, done, busy, m_c, m_zero);
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_alu_directed();
    test_muldiv();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
